// File: rtl/multiplexer_4to1.sv
// One-of-four WIDTH-bit data selector.
// Provides a combinational selected output, a registered copy of it,
// and a registered copy of the select aligned with that copy.
module multiplexer_4to1 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_n,      // rising-edge clock; the name is historical
  input  logic             reset_n,    // asynchronous, active-low
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [WIDTH-1:0] input3,
  input  logic [WIDTH-1:0] input4,
  output logic [WIDTH-1:0] selected,
  output logic [WIDTH-1:0] selected_q,
  output logic [1:0]       sel_q
);

  logic [WIDTH-1:0] selected_d;
  logic [1:0]       sel_d;

  // Steer one source onto the output. An unknown select falls through to
  // the default so no X from an unselected source leaks onto the bus.
  always_comb begin
    selected = '0;
    case (sel)
      2'b00:   selected = input1;
      2'b01:   selected = input2;
      2'b10:   selected = input3;
      2'b11:   selected = input4;
      default: selected = '0;
    endcase
  end

  // Next-state values: the registers reload every cycle with no hold.
  always_comb begin
    selected_d = selected;
    sel_d      = sel;
  end

  // Capture the settled selection on each rising edge; clear at once on reset.
  always_ff @(posedge clk_n or negedge reset_n) begin
    if (!reset_n) begin
      selected_q <= '0;
      sel_q      <= 2'b00;
    end else begin
      selected_q <= selected_d;
      sel_q      <= sel_d;
    end
  end

endmodule

// File: tb/tb_multiplexer_4to1.sv
// Self-checking bench for multiplexer_4to1 at WIDTH=4 and WIDTH=8.
module tb_multiplexer_4to1;

  logic       clk_n;
  logic       reset_n;
  logic [1:0] sel;
  logic [7:0] in1, in2, in3, in4;

  logic [3:0] s4, sq4;
  logic [1:0] selq4;
  logic [7:0] s8, sq8;
  logic [1:0] selq8;

  int total = 0;
  int bad   = 0;

  multiplexer_4to1 #(.WIDTH(4)) u_dut4 (
    .clk_n      (clk_n),
    .reset_n    (reset_n),
    .sel        (sel),
    .input1     (in1[3:0]),
    .input2     (in2[3:0]),
    .input3     (in3[3:0]),
    .input4     (in4[3:0]),
    .selected   (s4),
    .selected_q (sq4),
    .sel_q      (selq4)
  );

  multiplexer_4to1 #(.WIDTH(8)) u_dut8 (
    .clk_n      (clk_n),
    .reset_n    (reset_n),
    .sel        (sel),
    .input1     (in1),
    .input2     (in2),
    .input3     (in3),
    .input4     (in4),
    .selected   (s8),
    .selected_q (sq8),
    .sel_q      (selq8)
  );

  initial clk_n = 1'b0;
  always #5 clk_n = ~clk_n;

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0] sel;
    logic [7:0] a, b, c, d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h exp=%h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{2'b00, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'hA5};
    vecs[1] = '{2'b01, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h5A};
    vecs[2] = '{2'b10, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'hFF};
    vecs[3] = '{2'b11, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h00};
    vecs[4] = '{2'b00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01};
    vecs[5] = '{2'b01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h02};
    vecs[6] = '{2'b10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h03};
    vecs[7] = '{2'b11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    vecs[8] = '{2'b10, 8'h3C, 8'hC3, 8'h81, 8'h7E, 8'h81};

    // Reset held: registered outputs are zero, combinational path still works.
    reset_n = 1'b0;
    sel     = 2'b00;
    in1 = 8'h01; in2 = 8'h02; in3 = 8'h03; in4 = 8'h04;
    #2;
    chk("reset_selq4", {4'h0, sq4}, 8'h00);
    chk("reset_selq8", sq8, 8'h00);
    chk("reset_sel_q", {6'h0, selq8}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      chk("comb_in_reset", {4'h0, s4}, 8'(i + 1));
      chk("regq_in_reset", {4'h0, sq4}, 8'h00);
      #19;
    end

    // Release reset away from an edge.
    @(negedge clk_n);
    reset_n = 1'b1;

    // Table: combinational value, then registered value one edge later.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_n);
      sel = vecs[i].sel;
      in1 = vecs[i].a; in2 = vecs[i].b; in3 = vecs[i].c; in4 = vecs[i].d;
      #1;
      chk("tbl_comb8", s8, vecs[i].exp);
      chk("tbl_comb4", {4'h0, s4}, {4'h0, vecs[i].exp[3:0]});
      @(posedge clk_n);
      #1;
      chk("tbl_reg8", sq8, vecs[i].exp);
      chk("tbl_reg4", {4'h0, sq4}, {4'h0, vecs[i].exp[3:0]});
      chk("tbl_selq", {6'h0, selq4}, {6'h0, vecs[i].sel});
    end

    // Registered path: sel=10 then 11.
    @(negedge clk_n);
    in1 = 8'h01; in2 = 8'h02; in3 = 8'h03; in4 = 8'h04;
    sel = 2'b10;
    @(posedge clk_n); #1;
    chk("reg_sel10", {4'h0, sq4}, 8'h03);
    chk("reg_selq10", {6'h0, selq4}, 8'h02);
    @(negedge clk_n);
    sel = 2'b11;
    #1;
    chk("reg_hold_before_edge", {4'h0, sq4}, 8'h03);
    @(posedge clk_n); #1;
    chk("reg_sel11", {4'h0, sq4}, 8'h04);

    // Async reset between edges.
    @(negedge clk_n);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_q", {4'h0, sq4}, 8'h00);
    chk("async_rst_selq", {6'h0, selq4}, 8'h00);
    chk("async_rst_comb", {4'h0, s4}, 8'h04);
    sel = 2'b01;
    @(posedge clk_n); #1;
    chk("rst_hold_q", {4'h0, sq4}, 8'h00);

    // Release with sel=01: zero until the next rising edge, then 2.
    @(negedge clk_n);
    reset_n = 1'b1;
    #1;
    chk("release_pre_edge", {4'h0, sq4}, 8'h00);
    @(posedge clk_n); #1;
    chk("release_post_edge", {4'h0, sq4}, 8'h02);
    chk("release_selq", {6'h0, selq4}, 8'h01);

    // Unknown select yields zero (only observable on a four-state simulator).
    sel = 2'bxx;
    #1;
    if ($isunknown(sel)) begin
      chk("sel_x_comb4", {4'h0, s4}, 8'h00);
      chk("sel_x_comb8", s8, 8'h00);
    end
    sel = 2'b00;
    #5;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
